// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead FIFO, one frame per popped byte.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fifo_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_fifo_rd_en,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                r_state;
   state_t                w_nextState;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [BAUD_W-1:0]     r_baud;
   logic [BIT_W-1:0]      r_bit;
   logic                  w_wrap;
   logic                  w_rdEn;
`ifdef UART_TX_PARITY_EN
   logic                  r_par;
`endif

   assign w_wrap = (r_baud == BAUD_LAST);

   // A pop starts a frame from IDLE, or chains one straight after a stop bit.
   assign w_rdEn = !i_rst && !i_fifo_empty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_wrap));

   assign o_fifo_rd_en = w_rdEn;
   assign o_busy       = (r_state != IDLE);
   assign o_done       = (r_state == STOP) && w_wrap;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      o_tx        = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_rdEn) w_nextState = START;
         end
         START: begin
            o_tx = 1'b0;
            if (w_wrap) w_nextState = DATA;
         end
         DATA: begin
            o_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            if (w_wrap && (r_bit == BIT_LAST)) w_nextState = PARITY;
`else
            if (w_wrap && (r_bit == BIT_LAST)) w_nextState = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            o_tx = r_par;
            if (w_wrap) w_nextState = STOP;
         end
`endif
         STOP: begin
            if (w_wrap) w_nextState = w_rdEn ? START : IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath: the byte is captured on the pop, so later FIFO changes cannot reach the line.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shift <= '0;
         r_baud  <= '0;
         r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (w_rdEn) begin
         r_shift <= i_fifo_data;
         r_baud  <= '0;
         r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (r_state != IDLE) begin
         r_baud <= w_wrap ? '0 : r_baud + BAUD_W'(1);
         if ((r_state == DATA) && w_wrap) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + BIT_W'(1);
`ifdef UART_TX_PARITY_EN
            r_par   <= r_par ^ r_shift[0];
`endif
         end
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a queue standing in for the FIFO.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       fifoEmpty;
   logic [7:0] fifoData;
   logic       rdEn;
   logic       tx;
   logic       busy;
   logic       done;

   logic [7:0] fifoQ[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [10:0] seen;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
      .i_clk        (clk),
      .i_rst        (reset),
      .i_fifo_empty (fifoEmpty),
      .i_fifo_data  (fifoData),
      .o_fifo_rd_en (rdEn),
      .o_tx         (tx),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
      end
   endtask

   task automatic updateFifo();
      fifoEmpty = (fifoQ.size() == 0);
      fifoData  = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      fifoQ.push_back(b);
      updateFifo();
      #1;
   endtask

   // One clock: pop the model FIFO if the DUT requested it in the cycle just ended.
   task automatic tick();
      logic popNow;
      popNow = rdEn;
      @(posedge clk);
      #1;
      if (popNow && fifoQ.size() > 0) void'(fifoQ.pop_front());
      updateFifo();
   endtask

   function automatic logic frameBit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Called in the cycle the pop is expected; walks the whole frame cycle by cycle.
   task automatic runFrame(input logic [7:0] b, input bit scramble, output logic [10:0] bits);
      int last;
      int bitIdx;
      last = FRAME_BITS * CPB;
      bits = '0;
      checkOutput("rdEnStart", rdEn, 1);
      for (int k = 1; k <= last; k++) begin
         tick();
         if (scramble && fifoQ.size() > 0)
            fifoData = (k == last) ? fifoQ[0] : 8'($urandom);
         #1;
         bitIdx = (k - 1) / CPB;
         checkOutput("tx", tx, frameBit(b, bitIdx));
         checkOutput("busy", busy, 1);
         checkOutput("done", done, (k == last));
         checkOutput("rdEn", rdEn, (k == last) && (fifoQ.size() > 0));
         if ((k - 1) % CPB == CPB / 2) bits[bitIdx] = tx;
      end
   endtask

   task automatic idleCheck(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         checkOutput("idleTx", tx, 1);
         checkOutput("idleBusy", busy, 0);
         checkOutput("idleRdEn", rdEn, 0);
         checkOutput("idleDone", done, 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      updateFifo();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstTx", tx, 1);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstRdEn", rdEn, 0);
      reset = 1'b0;
      #1;
      idleCheck(20);

      $display("[TB] single frame 0xA5");
      applyStimulus(8'hA5);
      runFrame(8'hA5, 1'b0, seen);
`ifdef UART_TX_PARITY_EN
      checkOutput("frameA5", {21'b0, seen}, {21'b0, 11'b10101001010});
`else
      checkOutput("frameA5", {21'b0, seen}, {22'b0, 10'b1101001010});
`endif
      idleCheck(5);

      $display("[TB] back-to-back 0x01 0x02 0x03");
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      runFrame(8'h01, 1'b0, seen);
      runFrame(8'h02, 1'b0, seen);
      runFrame(8'h03, 1'b0, seen);
      checkOutput("fifoDrained", fifoQ.size(), 0);
      idleCheck(10);

`ifdef UART_TX_PARITY_EN
      $display("[TB] parity frames 0x07 0xA5");
      applyStimulus(8'h07);
      applyStimulus(8'hA5);
      runFrame(8'h07, 1'b0, seen);
      checkOutput("parity07", seen[9], 1);
      runFrame(8'hA5, 1'b0, seen);
      checkOutput("parityA5", seen[9], 0);
      idleCheck(5);
`endif

      $display("[TB] async reset during start bit");
      applyStimulus(8'h00);
      checkOutput("rdEn00", rdEn, 1);
      tick();
      checkOutput("startTx", tx, 0);
      reset = 1'b1;
      #1;
      checkOutput("asyncTx", tx, 1);
      checkOutput("asyncBusy", busy, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      idleCheck(3);

      $display("[TB] reset in data of 0xFF, then 0x3C");
      applyStimulus(8'hFF);
      checkOutput("rdEnFF", rdEn, 1);
      repeat (10) tick();
      checkOutput("ffBusy", busy, 1);
      reset = 1'b1;
      #1;
      checkOutput("ffRstTx", tx, 1);
      checkOutput("ffRstBusy", busy, 0);
      applyStimulus(8'h3C);
      checkOutput("rstRdEnForced", rdEn, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      runFrame(8'h3C, 1'b0, seen);
      idleCheck(5);

      $display("[TB] head data changing after the pop");
      applyStimulus(8'h96);
      applyStimulus(8'h3C);
      runFrame(8'h96, 1'b1, seen);
      runFrame(8'h3C, 1'b0, seen);
      idleCheck(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
